// File: rtl/hazard_ctrl_fsm.sv
// Pipeline hazard controller: prioritised stall/flush generation, memory-wait FSM with timeout.
// Optional perf counters (stall_cycles, mispred_cnt) are built only when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl_fsm #(
  parameter int REG_AW = 5,
  parameter int MEM_TO = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              branch_d,
  input  logic              jump_d,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] writereg_e,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic [REG_AW-1:0] writereg_m,
  input  logic              memtoreg_m,
  input  logic              memread_m,
  input  logic              memwrite_m,
  input  logic              memready_m,
  input  logic              branchtaken_e,
  input  logic              branchfound_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic              mispredict_e,
  output logic              mem_wait,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  mispred_cnt
);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_op;
  logic             mem_stall;
  logic             br_haz;
  logic             lu_haz;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A producer of r0 never hazards, whatever the consumers read.
  function automatic logic reg_match(input logic [REG_AW-1:0] prod,
                                     input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
    return (prod != '0) && ((prod == a) || (prod == b));
  endfunction

  assign mem_op    = memread_m | memwrite_m;
  assign mem_stall = mem_op & ~memready_m;
  assign br_haz    = branch_d & ((regwrite_e & reg_match(writereg_e, rs_d, rt_d)) |
                                 (memtoreg_m & reg_match(writereg_m, rs_d, rt_d)));
  assign lu_haz    = memtoreg_e & reg_match(rt_e, rs_d, rt_d);

  // A held memory op keeps E frozen, so a pending mispredict resurfaces once it completes.
  assign mispredict_e = reset & ~mem_stall & (branchtaken_e ^ branchfound_e);

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (reset) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (mispredict_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (jump_d) begin
        flush_d = 1'b1;
      end else if (br_haz | lu_haz) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_wait    <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_WAIT;
            wait_cnt <= CNT_W'(1);
            mem_wait <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (memready_m || !mem_op) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            mem_wait <= 1'b0;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
            if (wait_cnt == CNT_W'(MEM_TO - 1))
              mem_timeout <= 1'b1;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
          mem_wait <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  // mispredict_e is already masked by mem_stall, so it marks exactly the priority-2 flush cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (stall_f)
        stall_cnt_q <= sat_inc(stall_cnt_q);
      if (mispredict_e)
        mispred_cnt_q <= sat_inc(mispred_cnt_q);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign mispred_cnt  = mispred_cnt_q;
`else
  assign stall_cycles = '0;
  assign mispred_cnt  = '0;
`endif

endmodule
